// File: rtl/handshake_rr_arbiter_if.sv
// Valid/ready bundle between NUM_REQ sources, the arbiter and one sink.
// slave: arbiter side; master: the surrounding sources and sink.
interface handshake_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_ready;
  logic                          m_valid;
  logic [DATA_WIDTH-1:0]         m_data;
  logic [IDX_W-1:0]              m_src;
  logic                          m_ready;
  logic                          busy;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_src, busy
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_src, busy
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: one valid/ready sink shared by NUM_REQ sources.
// A grant is locked for up to MAX_BURST beats, then one ARB cycle follows.
module handshake_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   rst,
  handshake_rr_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] TOP  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] gnt, gnt_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;

  logic [IDX_W-1:0]      pick;
  logic                  found;
  logic                  cur_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] src_data [NUM_REQ];
  logic [NUM_REQ-1:0]    ready;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_data[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan from rr_ptr upward; wrap is exact for any NUM_REQ.
  always_comb begin
    logic [IDX_W:0] idx;
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.s_valid[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  assign cur_valid = bus.s_valid[gnt];
  assign accept    = (state == LOCK) && cur_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    unique case (state)
      ARB: begin
        if (found) begin
          state_nx    = LOCK;
          gnt_nx      = pick;
          beat_cnt_nx = '0;
        end
      end
      LOCK: begin
        if (accept) beat_cnt_nx = beat_cnt + 1'b1;
        if (!cur_valid || (accept && beat_cnt == LAST)) begin
          state_nx  = ARB;
          rr_ptr_nx = (gnt == TOP) ? '0 : gnt + 1'b1;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // Outputs see only state/gnt and the granted source, never the scan.
  always_comb begin
    ready       = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_src   = '0;
    bus.busy    = 1'b0;
    if (state == LOCK) begin
      ready[gnt]  = bus.m_ready;
      bus.m_valid = cur_valid;
      bus.m_data  = src_data[gnt];
      bus.m_src   = gnt;
      bus.busy    = 1'b1;
    end
  end

  assign bus.s_ready = ready;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter (4-source and 3-source builds).
// Sources are modelled as beat tables popped on each completed handshake.
module tb_handshake_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_rr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();
  handshake_rr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(3)) bus3 ();

  handshake_rr_arbiter #(
    .DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4), .IDX_W(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  handshake_rr_arbiter #(
    .DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(2), .IDX_W(2)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [4][16];
  int         cnt  [4];
  int         head [4];
  logic [3:0] en;
  logic [3:0] hs;

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      head[i] = 0;
    end
    en = 4'hF;
  endtask

  task automatic drive();
    logic [3:0]  v;
    logic [31:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && head[i] < cnt[i]) begin
        v[i]       = 1'b1;
        d[i*8 +: 8] = mem[i][head[i]];
      end
    end
    bus.s_valid = v;
    bus.s_data  = d;
  endtask

  task automatic advance();
    hs = bus.s_ready & bus.s_valid;
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    bus.m_ready  = 1'b1;
    bus3.s_valid = '0;
    bus3.s_data  = '0;
    bus3.m_ready = 1'b1;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive();
    #1;
    n_assert++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset m_valid got %b want 0", bus.m_valid);
    end
    n_assert++;
    if (bus.s_ready !== 4'b0) begin
      n_fail++; $display("FAIL reset s_ready got %b want 0000", bus.s_ready);
    end
    n_assert++;
    if (bus.m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset m_data got %h want 00", bus.m_data);
    end
    n_assert++;
    if (bus.m_src !== 2'd0) begin
      n_fail++; $display("FAIL reset m_src got %0d want 0", bus.m_src);
    end
    n_assert++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy got %b want 0", bus.busy);
    end
    n_assert++;
    if (dut.rr_ptr !== 2'd0 || dut.beat_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset regs rr_ptr=%0d beat_cnt=%0d want 0 0",
               dut.rr_ptr, dut.beat_cnt);
    end
    n_assert++;
    if (bus3.m_valid !== 1'b0 || bus3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset3 m_valid=%b busy=%b want 0 0",
               bus3.m_valid, bus3.busy);
    end
    advance();
  endtask

  task automatic test_single();
    bit         ev [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    bit         eb [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [7:0] ed [10] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                            8'h00, 8'hA4, 8'hA5, 8'h00, 8'h00};
    do_reset();
    for (int k = 0; k < 6; k++) mem[2][k] = 8'hA0 + 8'(k);
    cnt[2] = 6;
    for (int c = 0; c < 10; c++) begin
      drive();
      #1;
      n_assert++;
      if (bus.m_valid !== ev[c] || bus.busy !== eb[c]) begin
        n_fail++;
        $display("FAIL single c%0d m_valid=%b busy=%b want %b %b",
                 c, bus.m_valid, bus.busy, ev[c], eb[c]);
      end
      if (ev[c]) begin
        n_assert++;
        if (bus.m_data !== ed[c] || bus.s_ready !== 4'b0100) begin
          n_fail++;
          $display("FAIL single c%0d m_data=%h s_ready=%b want %h 0100",
                   c, bus.m_data, bus.s_ready, ed[c]);
        end
      end
      if (eb[c]) begin
        n_assert++;
        if (bus.m_src !== 2'd2) begin
          n_fail++;
          $display("FAIL single c%0d m_src=%0d want 2", c, bus.m_src);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    int g;
    int b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) mem[i][k] = 8'(i*16 + k);
      cnt[i] = 8;
    end
    for (int c = 0; c <= 40; c++) begin
      g = (c / 5) % 4;
      b = (c / 5) / 4 * 4 + (c % 5) - 1;
      drive();
      #1;
      if (c % 5 == 0) begin
        n_assert++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL contention bubble c%0d m_valid=%b busy=%b want 0 0",
                   c, bus.m_valid, bus.busy);
        end
      end else begin
        n_assert++;
        if (bus.m_valid !== 1'b1 || bus.m_src !== 2'(g) ||
            bus.m_data !== 8'(g*16 + b) || bus.s_ready !== 4'(1 << g)) begin
          n_fail++;
          $display("FAIL contention c%0d v=%b src=%0d data=%h rdy=%b want 1 %0d %h %b",
                   c, bus.m_valid, bus.m_src, bus.m_data, bus.s_ready,
                   g, 8'(g*16 + b), 4'(1 << g));
        end
      end
      advance();
    end
    n_assert++;
    if (head[0] + head[1] + head[2] + head[3] != 32) begin
      n_fail++;
      $display("FAIL contention total beats got %0d want 32",
               head[0] + head[1] + head[2] + head[3]);
    end
  endtask

  task automatic test_backpressure();
    bit         ev [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [7:0] ed [14] = '{8'h00, 8'hB0, 8'hB1, 8'hB2, 8'hB2, 8'hB2,
                            8'hB2, 8'hB2, 8'hB2, 8'hB3, 8'h00, 8'hB4,
                            8'hB5, 8'h00};
    do_reset();
    for (int k = 0; k < 6; k++) mem[1][k] = 8'hB0 + 8'(k);
    cnt[1] = 6;
    for (int c = 0; c < 14; c++) begin
      bus.m_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
      drive();
      #1;
      n_assert++;
      if (bus.m_valid !== ev[c]) begin
        n_fail++;
        $display("FAIL backpressure c%0d m_valid=%b want %b",
                 c, bus.m_valid, ev[c]);
      end
      if (ev[c]) begin
        n_assert++;
        if (bus.m_data !== ed[c] || bus.m_src !== 2'd1 ||
            bus.s_ready !== {2'b00, bus.m_ready, 1'b0}) begin
          n_fail++;
          $display("FAIL backpressure c%0d data=%h src=%0d rdy=%b want %h 1 %b",
                   c, bus.m_data, bus.m_src, bus.s_ready, ed[c],
                   {2'b00, bus.m_ready, 1'b0});
        end
      end
      if (c >= 3 && c <= 7) begin
        n_assert++;
        if (dut.beat_cnt !== 3'd2) begin
          n_fail++;
          $display("FAIL backpressure c%0d beat_cnt=%0d want 2",
                   c, dut.beat_cnt);
        end
      end
      if (c == 10) begin
        n_assert++;
        if (bus.busy !== 1'b0 || head[1] != 4) begin
          n_fail++;
          $display("FAIL backpressure burst busy=%b beats=%0d want 0 4",
                   bus.busy, head[1]);
        end
      end
      advance();
    end
    bus.m_ready = 1'b1;
  endtask

  task automatic test_early_drop();
    bit         ev [7] = '{0, 1, 1, 0, 0, 1, 0};
    bit         eb [7] = '{0, 1, 1, 1, 0, 1, 1};
    logic [1:0] es [7] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [7:0] ed [7] = '{8'h00, 8'hD0, 8'hD1, 8'h00, 8'h00, 8'hE0, 8'h00};
    do_reset();
    mem[3][0] = 8'hD0;
    mem[3][1] = 8'hD1;
    cnt[3]    = 2;
    mem[0][0] = 8'hE0;
    cnt[0]    = 1;
    en[0]     = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) en[0] = 1'b1;
      drive();
      #1;
      n_assert++;
      if (bus.m_valid !== ev[c] || bus.busy !== eb[c]) begin
        n_fail++;
        $display("FAIL early_drop c%0d m_valid=%b busy=%b want %b %b",
                 c, bus.m_valid, bus.busy, ev[c], eb[c]);
      end
      if (eb[c]) begin
        n_assert++;
        if (bus.m_src !== es[c] || (ev[c] && bus.m_data !== ed[c])) begin
          n_fail++;
          $display("FAIL early_drop c%0d src=%0d data=%h want %0d %h",
                   c, bus.m_src, bus.m_data, es[c], ed[c]);
        end
      end
      if (c == 4) begin
        n_assert++;
        if (dut.rr_ptr !== 2'd0) begin
          n_fail++;
          $display("FAIL early_drop rr_ptr=%0d want 0", dut.rr_ptr);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) mem[1][k] = 8'hF0 + 8'(k);
    cnt[1]    = 4;
    mem[3][0] = 8'hC0;
    mem[3][1] = 8'hC1;
    cnt[3]    = 2;
    for (int c = 0; c < 5; c++) begin
      rst = (c == 2);
      drive();
      #1;
      if (c == 2) begin
        n_assert++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hF1) begin
          n_fail++;
          $display("FAIL reset_mid pre v=%b data=%h want 1 f1",
                   bus.m_valid, bus.m_data);
        end
      end
      if (c == 3) begin
        n_assert++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 4'b0 ||
            bus.m_data !== 8'h00 || bus.m_src !== 2'd0 ||
            bus.busy !== 1'b0 || dut.state !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid post v=%b rdy=%b data=%h src=%0d busy=%b st=%b want all 0",
                   bus.m_valid, bus.s_ready, bus.m_data, bus.m_src,
                   bus.busy, dut.state);
        end
      end
      if (c == 4) begin
        n_assert++;
        if (bus.m_valid !== 1'b1 || bus.m_src !== 2'd1 ||
            bus.m_data !== 8'hF1) begin
          n_fail++;
          $display("FAIL reset_mid regrant v=%b src=%0d data=%h want 1 1 f1",
                   bus.m_valid, bus.m_src, bus.m_data);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_nonpow2();
    int s;
    do_reset();
    drive();
    bus3.s_valid = 3'b101;
    bus3.s_data  = {8'h32, 8'h21, 8'h10};
    for (int c = 0; c < 15; c++) begin
      s = ((c / 3) % 2 == 0) ? 0 : 2;
      #1;
      if (c % 3 == 0) begin
        n_assert++;
        if (bus3.m_valid !== 1'b0 || bus3.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL nonpow2 bubble c%0d v=%b busy=%b want 0 0",
                   c, bus3.m_valid, bus3.busy);
        end
      end else begin
        n_assert++;
        if (bus3.m_valid !== 1'b1 || bus3.m_src !== 2'(s) ||
            bus3.m_data !== ((s == 0) ? 8'h10 : 8'h32) ||
            bus3.s_ready !== 3'(1 << s)) begin
          n_fail++;
          $display("FAIL nonpow2 c%0d v=%b src=%0d data=%h rdy=%b want 1 %0d",
                   c, bus3.m_valid, bus3.m_src, bus3.m_data,
                   bus3.s_ready, s);
        end
      end
      @(negedge clk);
    end
    bus3.s_valid = '0;
  endtask

  initial begin
    bus.s_valid  = '0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    bus3.s_valid = '0;
    bus3.s_data  = '0;
    bus3.m_ready = 1'b1;
    clear_src();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_drop();
    test_reset_mid();
    test_nonpow2();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
